seg_scan_arbiter: RTL and testbench
===================================

# seg_scan_arbiter

Controller for the four-digit multiplexed seven-segment display on the board. It derives the digit-refresh rate from the system clock, scans the four anodes, and feeds a 4-bit hex nibble to the downstream nibble-to-segment decoder. It also arbitrates the single display between two 16-bit requesters: CPU (port 0, priority) and debug (port 1, starvation-protected). The shown value changes only at frame boundaries, so digits never tear.

## Interface
- CLK_DIV, 50000: system clocks per digit slot; legal range ≥ 2.
- STARVE_LIM, 8: consecutive frame boundaries port 1 may be denied before it is forced a grant; legal range 1..255.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0  in  1  CPU display request (level).
- data0  in  16  CPU value; sampled only when granted.
- req1  in  1  debug display request (level).
- data1  in  16  debug value; sampled only when granted.
- ack0  out  1  one-cycle pulse: data0 was latched.
- ack1  out  1  one-cycle pulse: data1 was latched.
- AN  out  4  anode enables, active low; one-hot-zero.
- smallbin  out  4  nibble for the currently enabled digit.
- owner  out  2  01 = CPU value shown, 10 = debug value shown, 00 = none since reset.
- frame_done  out  1  one-cycle pulse when slot 3 begins.

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 and wraps. Internal `tick` is high in the cycle `pcnt == CLK_DIV-1`.
- Slot pointer `ptr` (2 bits) is the next digit to drive.
- On each tick:
  - AN ← one-hot-low for `ptr` (0→1110, 1→1101, 2→1011, 3→0111).
  - smallbin ← shown[4·ptr+3 : 4·ptr].
  - ptr ← ptr+1, wrapping 3→0.
- Frame boundary is a tick with `ptr == 0`. Arbitration happens there, before the nibble is selected, so digit 0 of the new frame already shows the new value.
  - Force condition: req1 high and `wait1 == STARVE_LIM` → grant port 1.
  - Else if req0 is high → grant port 0.
  - Else if req1 is high → grant port 1.
  - Else no grant: `shown` and `owner` hold.
- On a grant:
  - `shown` ← data of the granted port.
  - `owner` ← that port's code.
  - The port's ack pulses for one cycle.
- Starvation counter `wait1` (8 bits), updated at frame boundaries only:
  - Increments, saturating at STARVE_LIM, when req1 is high and port 1 is not granted.
  - Clears when port 1 is granted or req1 is low.
- frame_done pulses in the cycle AN becomes 0111.
- Requesters hold req and data stable until their ack. Deasserting req before ack is legal; the request is simply dropped. Reasserting req after an ack re-requests at the next boundary.

## Timing
- Reset values:
  - pcnt = 0, ptr = 0, wait1 = 0, shown = 16'h0000.
  - AN = 4'b1111, smallbin = 0, owner = 2'b00, ack0 = ack1 = 0, frame_done = 0.
- First tick occurs CLK_DIV cycles after rst deasserts. Digit 0 is driven in the following cycle. The display is blank until then.
- All outputs are registered: one cycle after the tick cycle. Ack, owner, AN and smallbin update in the same cycle.
- Frame period = 4·CLK_DIV cycles.
- Request-to-ack latency is at most 4·CLK_DIV + CLK_DIV cycles (the wait to the next boundary plus prescaler phase).
- Both requests high at a boundary: port 0 wins unless the force condition holds.
- rst asserted mid-frame: every register returns to its reset value on the next edge. Pending requests are not remembered.
- Requests have no effect between boundaries.

## Configuration
- SEG_BLANK_EN: leading-zero blanking.
  - Defined: in slot k > 0, if shown[15:4k] == 0, AN stays 4'b1111 for that slot. smallbin still carries the nibble (0). Digit 0 is never blanked, so 16'h0000 shows a single "0".
  - Undefined: all four digits always light; zeros are displayed.

## Test plan
- Reset/scan: CLK_DIV=4, no requests. AN = 1111 for the first 4 cycles after reset, then cycles 1110, 1101, 1011, 0111 every 4 cycles, smallbin = 0. frame_done pulses with every AN = 0111.
- Single grant: req0=1, data0=16'hA5C3. At the next boundary: ack0 pulses, owner = 01, and digit slots 0..3 show 3, C, 5, A.
- Priority: req0 and req1 high, data1=16'h1234. Port 0 is granted; wait1 reaches STARVE_LIM=2 after 2 boundaries. The third boundary grants port 1: ack1 pulses, owner = 10, digits show 4, 3, 2, 1.
- Hold: drop both requests after a grant of 16'hBEEF. The value is displayed unchanged for 3 further frames, with no ack pulses.
- Blanking (SEG_BLANK_EN defined): shown = 16'h0007. Slot 0 AN = 1110 with smallbin 7; slots 1–3 AN = 1111. Without the macro, all slots enable.
- Mid-frame reset: assert rst while AN = 1011. The next cycle has AN = 1111, owner = 00 and shown = 0, and scanning restarts at slot 0 after CLK_DIV cycles.

Source files
------------

// File: rtl/seg_scan_arbiter.sv
// Four-digit seven-segment scan controller with two-port display arbitration.
// Optional leading-zero blanking is enabled by defining SEG_BLANK_EN.
`timescale 1ns/1ps
module seg_scan_arbiter #(
    parameter int CLK_DIV    = 50000,
    parameter int STARVE_LIM = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] data0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack0,
    output logic        ack1,
    output logic [3:0]  AN,
    output logic [3:0]  smallbin,
    output logic [1:0]  owner,
    output logic        frame_done
);

    localparam int              PW   = $clog2(CLK_DIV);
    localparam logic [PW-1:0]   PMAX = PW'(CLK_DIV - 1);
    localparam logic [7:0]      WLIM = 8'(STARVE_LIM);

    logic [PW-1:0] pcnt;
    logic [1:0]    ptr;
    logic [7:0]    wait1;
    logic [15:0]   shown;

    logic          tick;
    logic          boundary;
    logic          force1;
    logic          gnt0;
    logic          gnt1;
    logic          blank;
    logic [15:0]   shown_nxt;
    logic [3:0]    nib;
    logic [3:0]    an_sel;

    // Arbitration resolves before the nibble mux so digit 0 of a new frame
    // already carries the newly granted value.
    always_comb begin
        tick      = (pcnt == PMAX);
        boundary  = tick && (ptr == 2'd0);
        force1    = req1 && (wait1 == WLIM);
        gnt1      = boundary && (force1 || (req1 && !req0));
        gnt0      = boundary && !force1 && req0;
        shown_nxt = gnt1 ? data1 : (gnt0 ? data0 : shown);

        nib    = shown_nxt[3:0];
        an_sel = 4'b1110;
        case (ptr)
            2'd0: begin nib = shown_nxt[3:0];   an_sel = 4'b1110; end
            2'd1: begin nib = shown_nxt[7:4];   an_sel = 4'b1101; end
            2'd2: begin nib = shown_nxt[11:8];  an_sel = 4'b1011; end
            default: begin nib = shown_nxt[15:12]; an_sel = 4'b0111; end
        endcase

        blank = 1'b0;
`ifdef SEG_BLANK_EN
        case (ptr)
            2'd1:    blank = (shown_nxt[15:4]  == 12'h000);
            2'd2:    blank = (shown_nxt[15:8]  == 8'h00);
            2'd3:    blank = (shown_nxt[15:12] == 4'h0);
            default: blank = 1'b0;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pcnt       <= '0;
            ptr        <= 2'd0;
            wait1      <= 8'd0;
            shown      <= 16'h0000;
            AN         <= 4'b1111;
            smallbin   <= 4'h0;
            owner      <= 2'b00;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            ack0       <= gnt0;
            ack1       <= gnt1;
            frame_done <= tick && (ptr == 2'd3);
            pcnt       <= tick ? '0 : pcnt + PW'(1);

            if (tick) begin
                AN       <= blank ? 4'b1111 : an_sel;
                smallbin <= nib;
                ptr      <= ptr + 2'd1;
            end

            if (boundary) begin
                shown <= shown_nxt;
                if (gnt1)
                    owner <= 2'b10;
                else if (gnt0)
                    owner <= 2'b01;
                // wait1 counts consecutive boundaries at which port 1 was denied.
                if (req1 && !gnt1)
                    wait1 <= (wait1 == WLIM) ? wait1 : wait1 + 8'd1;
                else
                    wait1 <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_arbiter.sv
// Self-checking bench for seg_scan_arbiter: directed vector table, hand-written
// reset sequences, and randomized traffic against a frame-level reference model.
`timescale 1ns/1ps
module tb_seg_scan_arbiter;

    localparam int CLK_DIV = 4;
    localparam int LIM     = 2;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req0  = 1'b0;
    logic        req1  = 1'b0;
    logic [15:0] data0 = 16'h0;
    logic [15:0] data1 = 16'h0;
    logic        ack0, ack1, frame_done;
    logic [3:0]  AN, smallbin;
    logic [1:0]  owner;

    int n_checks = 0;
    int n_fail   = 0;

    seg_scan_arbiter #(.CLK_DIV(CLK_DIV), .STARVE_LIM(LIM)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .data0(data0), .req1(req1), .data1(data1),
        .ack0(ack0), .ack1(ack1), .AN(AN), .smallbin(smallbin),
        .owner(owner), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [3:0] exp_an(input int slot, input logic [15:0] val);
        logic [3:0] a;
        a = ~(4'b0001 << slot);
`ifdef SEG_BLANK_EN
        if (slot > 0 && (val >> (4 * slot)) == 16'h0) a = 4'b1111;
`endif
        return a;
    endfunction

    // Reference model: cycle index since reset decides slot by division;
    // arbitration follows the boundary rules directly.
    bit          model_on = 0;
    int          c;
    int          m_wait;
    logic [15:0] m_shown;
    logic [1:0]  m_owner;
    logic [3:0]  e_an, e_sb;
    logic        e_ack0, e_ack1, e_fd;

    always @(negedge clk) begin
        int  slot;
        bit  g0, g1;
        if (rst) begin
            model_on = 1;
            c = 0; m_wait = 0; m_shown = 16'h0; m_owner = 2'b00;
            e_an = 4'b1111; e_sb = 4'h0; e_ack0 = 0; e_ack1 = 0; e_fd = 0;
        end else if (model_on) begin
            e_ack0 = 0; e_ack1 = 0; e_fd = 0;
            if (c % CLK_DIV == CLK_DIV - 1) begin
                slot = (c / CLK_DIV) % 4;
                if (slot == 0) begin
                    g1 = req1 && (m_wait >= LIM || !req0);
                    g0 = req0 && !g1;
                    if (g1) begin m_shown = data1; m_owner = 2'b10; e_ack1 = 1; end
                    else if (g0) begin m_shown = data0; m_owner = 2'b01; e_ack0 = 1; end
                    if (req1 && !g1) m_wait = (m_wait + 1 > LIM) ? LIM : m_wait + 1;
                    else m_wait = 0;
                end
                e_an = exp_an(slot, m_shown);
                e_sb = m_shown[4*slot +: 4];
                e_fd = (slot == 3);
            end
            c++;
        end
        if (model_on) begin
            chk("model_an", AN, e_an);
            chk("model_smallbin", smallbin, e_sb);
            chk("model_owner", owner, m_owner);
            chk("model_ack0", ack0, e_ack0);
            chk("model_ack1", ack1, e_ack1);
            chk("model_frame_done", frame_done, e_fd);
        end
    end

    typedef struct {
        bit          r0;
        logic [15:0] d0;
        bit          r1;
        logic [15:0] d1;
        logic [1:0]  own;
        bit          a0;
        bit          a1;
        logic [15:0] val;
    } row_t;

    row_t rows[12];

    task automatic apply(input bit r0, input logic [15:0] d0, input bit r1, input logic [15:0] d1);
        #1;
        req0 = r0; data0 = d0; req1 = r1; data1 = d1;
    endtask

    task automatic wait_an(input logic [3:0] pat, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (AN !== pat && n < 12 * CLK_DIV);
        chk(nm, AN, pat);
    endtask

    initial begin
        rows[0]  = '{1'b1, 16'hA5C3, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b0, 16'hA5C3};
        rows[1]  = '{1'b1, 16'h1111, 1'b1, 16'h1234, 2'b01, 1'b1, 1'b0, 16'h1111};
        rows[2]  = '{1'b1, 16'h1111, 1'b1, 16'h1234, 2'b01, 1'b1, 1'b0, 16'h1111};
        rows[3]  = '{1'b1, 16'h1111, 1'b1, 16'h1234, 2'b10, 1'b0, 1'b1, 16'h1234};
        rows[4]  = '{1'b1, 16'h1111, 1'b1, 16'h1234, 2'b01, 1'b1, 1'b0, 16'h1111};
        rows[5]  = '{1'b1, 16'hBEEF, 1'b0, 16'h0000, 2'b01, 1'b1, 1'b0, 16'hBEEF};
        rows[6]  = '{1'b0, 16'h5555, 1'b0, 16'h6666, 2'b01, 1'b0, 1'b0, 16'hBEEF};
        rows[7]  = '{1'b0, 16'h5555, 1'b0, 16'h6666, 2'b01, 1'b0, 1'b0, 16'hBEEF};
        rows[8]  = '{1'b0, 16'h5555, 1'b0, 16'h6666, 2'b01, 1'b0, 1'b0, 16'hBEEF};
        rows[9]  = '{1'b0, 16'h0000, 1'b1, 16'h0007, 2'b10, 1'b0, 1'b1, 16'h0007};
        rows[10] = '{1'b0, 16'h0000, 1'b0, 16'h0000, 2'b10, 1'b0, 1'b0, 16'h0007};
        rows[11] = '{1'b0, 16'h0000, 1'b1, 16'h0000, 2'b10, 1'b0, 1'b1, 16'h0000};

        // Reset and free-running scan with no requests
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("reset_an", AN, 4'b1111);
        chk("reset_owner", owner, 2'b00);
        #1 rst = 1'b0;
        for (int i = 0; i < CLK_DIV - 1; i++) begin
            @(negedge clk);
            chk("blank_after_reset", AN, 4'b1111);
        end
        @(negedge clk);
        chk("scan_first_an", AN, 4'b1110);
        chk("scan_first_nib", smallbin, 4'h0);
        for (int k = 1; k < 8; k++) begin
            repeat (CLK_DIV) @(negedge clk);
            chk("scan_an", AN, exp_an(k % 4, 16'h0));
            chk("scan_frame_done", frame_done, (k % 4 == 3) ? 1'b1 : 1'b0);
        end

        // Directed table, one row per frame boundary
        for (int r = 0; r < 12; r++) begin
            apply(rows[r].r0, rows[r].d0, rows[r].r1, rows[r].d1);
            wait_an(4'b1110, "row_boundary");
            chk("row_ack0", ack0, rows[r].a0);
            chk("row_ack1", ack1, rows[r].a1);
            chk("row_owner", owner, rows[r].own);
            chk("row_digit0", smallbin, rows[r].val[3:0]);
            for (int k = 1; k < 4; k++) begin
                repeat (CLK_DIV) @(negedge clk);
                chk("row_digit", smallbin, rows[r].val[4*k +: 4]);
                chk("row_digit_an", AN, exp_an(k, rows[r].val));
            end
        end

        // Mid-frame reset
        apply(1'b1, 16'h9876, 1'b0, 16'h0000);
        wait_an(4'b1110, "pre_reset_boundary");
        chk("pre_reset_ack0", ack0, 1'b1);
        apply(1'b0, 16'h9876, 1'b0, 16'h0000);
        wait_an(4'b1011, "pre_reset_slot2");
        #1 rst = 1'b1;
        @(negedge clk);
        chk("midreset_an", AN, 4'b1111);
        chk("midreset_owner", owner, 2'b00);
        chk("midreset_nib", smallbin, 4'h0);
        chk("midreset_ack0", ack0, 1'b0);
        #1 rst = 1'b0;
        for (int i = 0; i < CLK_DIV - 1; i++) begin
            @(negedge clk);
            chk("midreset_blank", AN, 4'b1111);
        end
        @(negedge clk);
        chk("midreset_restart_an", AN, 4'b1110);
        chk("midreset_restart_nib", smallbin, 4'h0);
        chk("midreset_restart_owner", owner, 2'b00);

        // Randomized traffic; the reference model does the checking
        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            #1;
            if (ack0 || !req0) begin
                req0  = ($urandom_range(0, 2) != 0);
                data0 = 16'($urandom);
            end else if ($urandom_range(0, 99) == 0) begin
                req0 = 1'b0;
            end
            if (ack1 || !req1) begin
                req1  = ($urandom_range(0, 1) != 0);
                data1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end else if ($urandom_range(0, 99) == 0) begin
                req1 = 1'b0;
            end
            rst = ($urandom_range(0, 799) == 0);
        end

        #1 rst = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
